// File: rtl/srv_icache_if.sv
// rtl/srv_icache_if.sv - fetch, refill and status signals of the instruction cache
//  slave  : cache side (receives fetch/refill inputs, drives data, refill request and miss count)
//  master : environment side (fetch unit plus line-refill responder)
interface srv_icache_if #(
    parameter int CNT_W = 16
);
    logic              imem_req_i;
    logic [31:0]       imem_addr_i;
    logic [31:0]       imem_data_o;
    logic              imem_vld_o;
    logic              inv_i;
    logic              ext_req_o;
    logic [31:0]       ext_addr_o;
    logic              ext_rsp_i;
    logic [127:0]      ext_data_i;
    logic [CNT_W-1:0]  miss_cnt_o;

    modport slave (
        input  imem_req_i, imem_addr_i, inv_i, ext_rsp_i, ext_data_i,
        output imem_data_o, imem_vld_o, ext_req_o, ext_addr_o, miss_cnt_o
    );

    modport master (
        output imem_req_i, imem_addr_i, inv_i, ext_rsp_i, ext_data_i,
        input  imem_data_o, imem_vld_o, ext_req_o, ext_addr_o, miss_cnt_o
    );
endinterface

// File: rtl/srv_icache.sv
// rtl/srv_icache.sv - direct-mapped instruction cache with single-outstanding line refill
//  clk   : clock, rising edge
//  rst_n : asynchronous active-low reset
//  bus   : srv_icache_if.slave - fetch port (imem_*), invalidate (inv_i),
//          refill port (ext_*), saturating refill counter (miss_cnt_o)
module srv_icache #(
    parameter int SETS  = 16,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    srv_icache_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state_ff;
    state_t             state_nx;
    logic [SETS-1:0]    valid_ff;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [127:0]       line_q [SETS];
    logic [31:0]        miss_addr_ff;
    logic [CNT_W-1:0]   miss_cnt_ff;

    logic [1:0]         f_word;
    logic [IDX_W-1:0]   f_idx;
    logic [TAG_W-1:0]   f_tag;
    logic [IDX_W-1:0]   m_idx;
    logic [TAG_W-1:0]   m_tag;
    logic               hit;
    logic               miss_start;
    logic               fill;
    logic               unused_addr_bits;

    assign f_word = bus.imem_addr_i[3:2];
    assign f_idx  = bus.imem_addr_i[4 +: IDX_W];
    assign f_tag  = bus.imem_addr_i[31:4+IDX_W];
    assign m_idx  = miss_addr_ff[4 +: IDX_W];
    assign m_tag  = miss_addr_ff[31:4+IDX_W];

    // Lookups are only answered in IDLE so a fetch never sees a half-installed line.
    assign hit        = bus.imem_req_i & valid_ff[f_idx] & (tag_q[f_idx] == f_tag)
                      & (state_ff == IDLE);
    assign miss_start = (state_ff == IDLE) & bus.imem_req_i & ~hit & ~bus.inv_i;
    assign fill       = (state_ff == WAIT) & bus.ext_rsp_i;

    assign bus.imem_vld_o  = hit;
    assign bus.imem_data_o = line_q[f_idx][{f_word, 5'b00000} +: 32];
    assign bus.ext_req_o   = (state_ff == REQ);
    assign bus.ext_addr_o  = {2'b00, miss_addr_ff[31:4], 2'b00};
    assign bus.miss_cnt_o  = miss_cnt_ff;

    // Byte-offset bits never select anything; the refill works on whole lines.
    assign unused_addr_bits = ^{bus.imem_addr_i[1:0], miss_addr_ff[3:0]};

    always_comb begin
        state_nx = state_ff;
        case (state_ff)
            IDLE:    if (miss_start)    state_nx = REQ;
            REQ:                        state_nx = WAIT;
            WAIT:    if (bus.ext_rsp_i) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_ff     <= IDLE;
            valid_ff     <= '0;
            miss_addr_ff <= '0;
            miss_cnt_ff  <= '0;
        end else begin
            state_ff <= state_nx;
            if (miss_start) begin
                miss_addr_ff <= bus.imem_addr_i;
                if (miss_cnt_ff != '1) begin
                    miss_cnt_ff <= miss_cnt_ff + CNT_W'(1);
                end
            end
            // Invalidate takes priority over a refill landing on the same edge.
            if (bus.inv_i) begin
                valid_ff <= '0;
            end else if (fill) begin
                valid_ff[m_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; valid_ff alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill) begin
            line_q[m_idx] <= bus.ext_data_i;
            tag_q[m_idx]  <= m_tag;
        end
    end
endmodule
